// File: rtl/axil_regbank.sv
// axil_regbank: parametrised AXI4-Lite slave register bank.
// AW and W are captured independently and commit together. Byte strobes are
// honoured. Each register has a write pulse. RO_MASK registers read hw_rd_data.
// Optional build macro AXIL_REGBANK_SLVERR_EN: out-of-range accesses and RO
// writes answer SLVERR. Without it, every response is OKAY.

module axil_regbank_reg #(
  parameter int DW = 32,
  parameter bit RO = 1'b0
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0] q
);
  // byte-lane merge on commit; RO storage never changes from its reset value
  always_ff @(posedge ACLK) begin
    if (!ARESETN) q <= '0;
    else if (we && !RO) begin
      for (int b = 0; b < DW/8; b++)
        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                             AWPROT,
  input  logic                                   AWVALID,
  output logic                                   AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                                   WVALID,
  output logic                                   WREADY,
  output logic [1:0]                             BRESP,
  output logic                                   BVALID,
  input  logic                                   BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                             ARPROT,
  input  logic                                   ARVALID,
  output logic                                   ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                             RRESP,
  output logic                                   RVALID,
  input  logic                                   RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_rd_data
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW/8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wbeat_t;

  logic                         rst_done;
  logic                         aw_held, w_held, commit;
  logic [IDX_W-1:0]             aw_idx, ar_idx;
  wbeat_t                       wbeat;
  logic [NUM_REGS-1:0][DW-1:0]  regs;
  logic [NUM_REGS-1:0]          sel_w;
  logic                         wr_ro, rd_hit;
  logic [DW-1:0]                rd_val;
  logic [1:0]                   wr_resp, rd_resp;

  // readies stay low in reset and for the first edge that samples release
  assign AWREADY = rst_done && !aw_held && !BVALID;
  assign WREADY  = rst_done && !w_held  && !BVALID;
  assign ARREADY = rst_done && !RVALID;
  assign commit  = aw_held && w_held;
  assign ar_idx  = ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign reg_q   = regs;

  // register-index decode for the held write and the incoming read
  always_comb begin
    sel_w  = '0;
    wr_ro  = 1'b0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        sel_w[i] = 1'b1;
        wr_ro    = RO_MASK[i];
      end
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? hw_rd_data[i*DW +: DW] : regs[i];
      end
    end
  end

`ifdef AXIL_REGBANK_SLVERR_EN
  assign wr_resp = (!(|sel_w) || wr_ro) ? 2'b10 : 2'b00;
  assign rd_resp = rd_hit ? 2'b00 : 2'b10;
`else
  assign wr_resp = 2'b00;
  assign rd_resp = 2'b00;
  logic unused_resp;
  assign unused_resp = &{1'b0, wr_ro, rd_hit};
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0],
                       ARADDR[ADDR_LSB-1:0], hw_rd_data};

  // marks the first cycle after reset release
  always_ff @(posedge ACLK) begin
    if (!ARESETN) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // write path: independent AW/W capture, joint commit, B response
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      wbeat        <= '0;
      BVALID       <= 1'b0;
      BRESP        <= 2'b00;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= commit ? sel_w : '0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_resp;
      end else begin
        if (AWVALID && AWREADY) begin
          aw_held <= 1'b1;
          aw_idx  <= AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (WVALID && WREADY) begin
          w_held <= 1'b1;
          wbeat  <= '{data: WDATA, strb: WSTRB};
        end
        if (BVALID && BREADY) BVALID <= 1'b0;
      end
    end
  end

  // per-register storage
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    axil_regbank_reg #(.DW(DW), .RO(RO_MASK[i])) u_reg (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .we      (commit && sel_w[i]),
      .wdata   (wbeat.data),
      .wstrb   (wbeat.strb),
      .q       (regs[i])
    );
  end

  // read path: load RDATA on AR handshake, hold until RREADY
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1;
      RDATA  <= rd_val;
      RRESP  <= rd_resp;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: randomized scoreboard bench for axil_regbank.
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;
  localparam logic [NR-1:0] RO_MASK = 8'h04;
`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [2:0] AWPROT = '0, ARPROT = '0;
  logic AWVALID = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [DW-1:0] WDATA = '0, RDATA;
  logic [DW/8-1:0] WSTRB = '0;
  logic [1:0] BRESP, RRESP;
  logic [NR*DW-1:0] reg_q, hw_rd_data = '0;
  logic [NR-1:0] reg_wr_pulse;

  always #5 ACLK = ~ACLK;

  axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(NR),
                 .C_S_AXI_ADDR_WIDTH(AW), .RO_MASK(RO_MASK)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .hw_rd_data(hw_rd_data));

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rexp_t;

  int n_checks = 0, n_pass = 0;
  logic [DW-1:0] model [NR];
  logic [1:0] bq [$];
  rexp_t rq [$];
  int pq [$];
  rexp_t mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitors: pop the expected response whenever the DUT presents one
  always @(negedge ACLK) if (ARESETN) begin
    if (BVALID && BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", BVALID, 0);
      else chk("bresp", BRESP, bq.pop_front());
    end
    if (RVALID && RREADY) begin
      if (rq.size() == 0) chk("r_unexpected", RVALID, 0);
      else begin
        mon_r = rq.pop_front();
        chk("rdata", RDATA, mon_r.data);
        chk("rresp", RRESP, mon_r.resp);
      end
    end
    for (int i = 0; i < NR; i++)
      if (reg_wr_pulse[i]) begin
        if (pq.size() == 0) chk("pulse_unexpected", reg_wr_pulse[i], 0);
        else chk("pulse_idx", i, pq.pop_front());
      end
  end

  task automatic check_regq();
    for (int i = 0; i < NR; i++) chk("reg_q", reg_q[i*DW +: DW], model[i]);
  endtask

  task automatic wait_b();
    int t = 0;
    @(negedge ACLK);
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    if (!BVALID) chk("b_timeout", BVALID, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int aw_d, input int w_d);
    int idx = int'(addr) / 4;
    if (idx < NR) begin
      pq.push_back(idx);
      if (!RO_MASK[idx])
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      bq.push_back(RO_MASK[idx] ? ERR_RESP : 2'b00);
    end else bq.push_back(ERR_RESP);
    fork
      begin
        int t = 0;
        repeat (aw_d) @(posedge ACLK);
        #1 AWADDR = addr; AWVALID = 1;
        @(negedge ACLK);
        while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
        if (!AWREADY) chk("aw_timeout", AWREADY, 1);
        @(posedge ACLK); #1 AWVALID = 0;
      end
      begin
        int t = 0;
        repeat (w_d) @(posedge ACLK);
        #1 WDATA = data; WSTRB = strb; WVALID = 1;
        @(negedge ACLK);
        while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
        if (!WREADY) chk("w_timeout", WREADY, 1);
        @(posedge ACLK); #1 WVALID = 0;
      end
    join
    wait_b();
    check_regq();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] hw2, input int hold);
    int idx = int'(addr) / 4;
    int t = 0;
    rexp_t e;
    for (int i = 0; i < NR; i++) hw_rd_data[i*DW +: DW] = $urandom();
    hw_rd_data[2*DW +: DW] = hw2;
    if (idx >= NR)          begin e.data = '0;                       e.resp = ERR_RESP; end
    else if (RO_MASK[idx])  begin e.data = hw_rd_data[idx*DW +: DW]; e.resp = 2'b00; end
    else                    begin e.data = model[idx];               e.resp = 2'b00; end
    rq.push_back(e);
    RREADY = (hold == 0);
    ARADDR = addr; ARVALID = 1;
    @(negedge ACLK);
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    if (!ARREADY) chk("ar_timeout", ARREADY, 1);
    @(posedge ACLK); #1 ARVALID = 0;
    @(negedge ACLK);
    chk("rd_latency", RVALID, 1);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge ACLK); #1;
        chk("rvalid_hold", RVALID, 1);
        chk("rdata_hold", RDATA, e.data);
      end
      RREADY = 1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  // AW/W separated by 3 cycles, then B held off for 5 cycles
  task automatic do_stagger(input bit aw_first, input logic [DW-1:0] data);
    int t = 0;
    model[5] = data; pq.push_back(5); bq.push_back(2'b00);
    BREADY = 0;
    if (aw_first) begin AWADDR = 6'h14; AWVALID = 1; end
    else begin WDATA = data; WSTRB = 4'hF; WVALID = 1; end
    @(negedge ACLK);
    while (!(aw_first ? AWREADY : WREADY) && t < 100) begin @(negedge ACLK); t++; end
    @(posedge ACLK); #1 AWVALID = 0; WVALID = 0;
    repeat (3) begin
      @(negedge ACLK);
      chk("stag_first_blocked", aw_first ? AWREADY : WREADY, 0);
      chk("stag_no_commit", BVALID, 0);
    end
    @(posedge ACLK); #1;
    if (aw_first) begin WDATA = data; WSTRB = 4'hF; WVALID = 1; end
    else begin AWADDR = 6'h14; AWVALID = 1; end
    t = 0;
    @(negedge ACLK);
    while (!(aw_first ? WREADY : AWREADY) && t < 100) begin @(negedge ACLK); t++; end
    if (!(aw_first ? WREADY : AWREADY)) chk("stag_second_timeout", 0, 1);
    @(posedge ACLK); #1 AWVALID = 0; WVALID = 0;
    @(negedge ACLK); chk("stag_commit_early", BVALID, 0);
    @(negedge ACLK); chk("stag_commit_edge", BVALID, 1);
    repeat (5) begin
      chk("stag_bvalid_hold", BVALID, 1);
      chk("stag_awready_low", AWREADY, 0);
      chk("stag_wready_low", WREADY, 0);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 BREADY = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    check_regq();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rdata", RDATA, 0);
    chk("rst_bresp", BRESP, 0);     chk("rst_rresp", RRESP, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    check_regq();
    @(posedge ACLK); #1 ARESETN = 1;
    @(posedge ACLK); #1;
    chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

    // basic writes then readbacks
    for (int i = 0; i < 4; i++) do_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(AW'(i*4), $urandom(), 0);

    // byte strobes
    do_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(6'h04, 32'h11223344, 4'b0101, 1, 0);
    chk("strobe_merge", reg_q[1*DW +: DW], 32'hAA22CC44);
    do_read(6'h04, $urandom(), 0);

    // staggered channels with B backpressure
    do_stagger(1'b1, 32'hCAFE0001);
    do_stagger(1'b0, 32'hCAFE0002);
    do_read(6'h14, $urandom(), 2);

    // read-only register
    do_write(6'h08, 32'h0, 4'hF, 0, 0);
    do_read(6'h08, 32'hDEADBEEF, 0);
    chk("ro_slice_zero", reg_q[2*DW +: DW], 0);

    // out-of-range
    do_read(6'h20, $urandom(), 0);
    do_write(6'h20, 32'h5A5A5A5A, 4'hF, 0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = AW'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom(), $urandom_range(0, 2));
    end

    // reset during a half-finished write
    AWADDR = 6'h04; AWVALID = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1 AWVALID = 0;
    @(posedge ACLK); #1 ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (6) begin @(negedge ACLK); chk("rst_mid_no_b", BVALID, 0); end
    check_regq();
    @(posedge ACLK); #1;
    do_write(6'h0C, 32'h600D600D, 4'hF, 0, 2);
    do_read(6'h0C, $urandom(), 0);

    repeat (3) @(negedge ACLK);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("pq_drained", pq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
